seq_alu_nbit: RTL and testbench
===============================

SEQ_ALU_NBIT -- requirements
Module: seq_alu_nbit

Interface
REQ-001: Parameter W, default 4, operand width in bits; legal range 2..16.
REQ-002: clk  input  1  single clock; all state changes on its rising edge.
REQ-003: rst  input  1  reset, asynchronous, active-high.
REQ-004: inA  input  W  operand A data for loading.
REQ-005: inB  input  W  operand B data for loading.
REQ-006: btnLoadA  input  1  level; regA <= inA on each rising edge while high.
REQ-007: btnLoadB  input  1  level; regB <= inB on each rising edge while high.
REQ-008: op  input  2  operation select: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-009: start  input  1  request; sampled only in IDLE.
REQ-010: result  output  2W  registered result.
REQ-011: flag_out  output  1  registered carry/borrow/overflow/div0 flag.
REQ-012: busy  output  1  high while an operation is in progress.
REQ-013: done  output  1  one-cycle pulse when result/flag_out become valid.

Function
REQ-014: The FSM SHALL have states IDLE, CALC, DONE; IDLE->CALC on start, CALC->DONE after the op latency, DONE->IDLE unconditionally after one cycle.
REQ-015: On the start edge in IDLE the block SHALL capture regA, regB and op into working registers; later loads SHALL NOT affect the running op.
REQ-016: Start and load on the same edge SHALL capture the pre-load regA/regB values.
REQ-017: start while busy, or in DONE, SHALL be ignored (no queuing).
REQ-018: busy SHALL be high from the edge after start is accepted until the edge entering DONE; busy and done SHALL never both be high.
REQ-019: Latency (start edge to done high) SHALL be 1 cycle for ADD, SUB and DIV-by-zero; W cycles for MUL and DIV.
REQ-020: ADD: result = zero-extended A+B; flag_out = carry (bit W of the sum).
REQ-021: SUB: result = 2W-bit two's complement of A-B; flag_out = 1 iff A < B (borrow).
REQ-022: MUL: shift-add, one multiplier bit per CALC cycle, LSB first; result = A*B; flag_out = 1 iff product >= 2^W.
REQ-023: DIV: restoring division, one quotient bit per CALC cycle, MSB first; result[2W-1:W] = remainder, result[W-1:0] = quotient; flag_out = 0.
REQ-024: DIV with B = 0: result[2W-1:W] = A, result[W-1:0] = all ones, flag_out = 1.
REQ-025: result and flag_out SHALL update only on the edge entering DONE and hold until the next DONE entry.
REQ-026: Arithmetic SHALL be unsigned on W-bit operands; all intermediates sized to avoid truncation.

Reset
REQ-027: rst high SHALL immediately force IDLE; regA, regB, result, flag_out, busy, done and working registers to 0.
REQ-028: Reset mid-operation SHALL abort it with no done pulse; the first op after release SHALL behave as from power-up.
REQ-029: start and btnLoad inputs SHALL be ignored while rst is high.

Verification (W = 4)
REQ-030: Load A=15, B=1, op=ADD, start -> done 1 cycle later, result=0x10, flag_out=1.
REQ-031: Load A=1, B=3, op=SUB, start -> result=0xFE, flag_out=1; A=3, B=1 -> result=0x02, flag_out=0.
REQ-032: Load A=15, B=15, op=MUL, start -> busy for 4 cycles, done pulse, result=0xE1 (225), flag_out=1; A=2, B=3 -> 0x06, flag_out=0.
REQ-033: Load A=13, B=4, op=DIV, start -> after 4 cycles result=0x13 (rem 1, quo 3), flag_out=0; A=9, B=0 -> done after 1 cycle, result=0x9F, flag_out=1.
REQ-034: Start DIV, pulse start and btnLoadA (inA=0) at cycle 2 -> second start ignored, result uses original A, regA=0 afterwards.
REQ-035: Assert rst at cycle 2 of a MUL -> outputs 0, no done pulse; a subsequent ADD 2+3 yields result=0x05, flag_out=0.

Source files
------------

// File: rtl/seq_alu_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_nbit
//  Description : Sequential unsigned ALU with W-bit operands. ADD and SUB
//                take one cycle. MUL is a shift-add unit that handles one
//                multiplier bit per cycle. DIV is a restoring divider that
//                produces one quotient bit per cycle. The result is 2W bits
//                wide and comes with a flag bit.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_alu_nbit #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     inA,
    input  logic [W-1:0]     inB,
    input  logic             btnLoadA,
    input  logic             btnLoadB,
    input  logic [1:0]       op,
    input  logic             start,
    output logic [2*W-1:0]   result,
    output logic             flag_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] c_lastCnt = CW'(W - 1);

    localparam logic [1:0] c_opAdd = 2'b00;
    localparam logic [1:0] c_opSub = 2'b01;
    localparam logic [1:0] c_opMul = 2'b10;
    localparam logic [1:0] c_opDiv = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_stateNext;

    logic [W-1:0]   r_regA;
    logic [W-1:0]   r_regB;
    logic [1:0]     r_op;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_opA;      // addend, minuend, or the dividend/quotient shift register
    logic [W-1:0]   r_opB;      // addend, subtrahend, multiplier shift register, or divisor
    logic [2*W-1:0] r_mcand;    // multiplicand, shifted left once per step
    logic [2*W-1:0] r_acc;      // partial product
    logic [W-1:0]   r_rem;      // partial remainder
    logic [2*W-1:0] r_result;
    logic           r_flag;

    logic [W:0]     w_sum;
    logic [2*W-1:0] w_diff;
    logic [2*W-1:0] w_mulAcc;
    logic [W:0]     w_trial;
    logic           w_ge;
    logic [W-1:0]   w_remSub;
    logic [W-1:0]   w_remNext;
    logic [W-1:0]   w_quoNext;
    logic           w_divZero;
    logic           w_finish;
    logic [2*W-1:0] w_resNext;
    logic           w_flagNext;

    assign w_sum     = {1'b0, r_opA} + {1'b0, r_opB};
    assign w_diff    = {{W{1'b0}}, r_opA} - {{W{1'b0}}, r_opB};
    assign w_mulAcc  = r_acc + (r_opB[0] ? r_mcand : {(2*W){1'b0}});

    // Restoring-division step: shift the next dividend bit into the remainder.
    // When the trial value is >= the divisor, the true difference is below
    // 2^W, so a W-bit subtraction is exact.
    assign w_trial   = {r_rem, r_opA[W-1]};
    assign w_ge      = (w_trial >= {1'b0, r_opB});
    assign w_remSub  = w_trial[W-1:0] - r_opB;
    assign w_remNext = w_ge ? w_remSub : w_trial[W-1:0];
    assign w_quoNext = {r_opA[W-2:0], w_ge};
    assign w_divZero = (r_opB == {W{1'b0}});

    assign result    = r_result;
    assign flag_out  = r_flag;

    // Decide whether this CALC cycle is the last one, and what the result and flag become
    always_comb begin
        w_finish   = 1'b0;
        w_resNext  = r_result;
        w_flagNext = r_flag;
        case (r_op)
            c_opAdd: begin
                w_finish   = 1'b1;
                w_resNext  = {{(W-1){1'b0}}, w_sum};
                w_flagNext = w_sum[W];
            end
            c_opSub: begin
                w_finish   = 1'b1;
                w_resNext  = w_diff;
                w_flagNext = (r_opA < r_opB);
            end
            c_opMul: begin
                w_finish   = (r_cnt == c_lastCnt);
                w_resNext  = w_mulAcc;
                w_flagNext = |w_mulAcc[2*W-1:W];
            end
            default: begin
                if (w_divZero) begin
                    w_finish   = 1'b1;
                    w_resNext  = {r_opA, {W{1'b1}}};
                    w_flagNext = 1'b1;
                end else begin
                    w_finish   = (r_cnt == c_lastCnt);
                    w_resNext  = {w_remNext, w_quoNext};
                    w_flagNext = 1'b0;
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic and the status outputs decoded from the state
    always_comb begin
        w_stateNext = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_stateNext = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (w_finish) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Operand loads, operand capture at start, iteration steps, result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regA   <= '0;
            r_regB   <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_opA    <= '0;
            r_opB    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_result <= '0;
            r_flag   <= 1'b0;
        end else begin
            if (btnLoadA) begin
                r_regA <= inA;
            end
            if (btnLoadB) begin
                r_regB <= inB;
            end
            case (r_state)
                IDLE: begin
                    // Operands are taken from the holding registers before
                    // any load on this same edge.
                    if (start) begin
                        r_op    <= op;
                        r_opA   <= r_regA;
                        r_opB   <= r_regB;
                        r_mcand <= {{W{1'b0}}, r_regA};
                        r_acc   <= '0;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_op == c_opMul) begin
                        r_acc   <= w_mulAcc;
                        r_mcand <= r_mcand << 1;
                        r_opB   <= r_opB >> 1;
                    end else if (r_op == c_opDiv) begin
                        r_rem   <= w_remNext;
                        r_opA   <= w_quoNext;
                    end
                    if (w_finish) begin
                        r_result <= w_resNext;
                        r_flag   <= w_flagNext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu_nbit
//  Description : Self-checking bench for seq_alu_nbit with W = 4. Expected
//                results go into a scoreboard queue when an operation is
//                started, and are popped and compared when done pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_alu_nbit;

    localparam int W = 4;

    localparam logic [1:0] c_opAdd = 2'b00;
    localparam logic [1:0] c_opSub = 2'b01;
    localparam logic [1:0] c_opMul = 2'b10;
    localparam logic [1:0] c_opDiv = 2'b11;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   inA;
    logic [W-1:0]   inB;
    logic           btnLoadA;
    logic           btnLoadB;
    logic [1:0]     op;
    logic           start;
    logic [2*W-1:0] result;
    logic           flag_out;
    logic           busy;
    logic           done;

    int total = 0;
    int bad   = 0;

    logic [2*W:0] expQ[$];

    seq_alu_nbit #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .inA      (inA),
        .inB      (inB),
        .btnLoadA (btnLoadA),
        .btnLoadB (btnLoadB),
        .op       (op),
        .start    (start),
        .result   (result),
        .flag_out (flag_out),
        .busy     (busy),
        .done     (done)
    );

    // 10 ns clock period
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: returns {flag, result} and the expected latency
    function automatic logic [2*W:0] model(input int a, input int b, input logic [1:0] o, output int lat);
        int  r;
        logic f;
        int  m;
        m = (1 << (2*W)) - 1;
        case (o)
            c_opAdd: begin r = a + b;         f = (r >= (1 << W)); lat = 1; end
            c_opSub: begin r = (a - b) & m;   f = (a < b);         lat = 1; end
            c_opMul: begin r = a * b;         f = (r >= (1 << W)); lat = W; end
            default: begin
                if (b == 0) begin
                    r = (a << W) | ((1 << W) - 1); f = 1'b1; lat = 1;
                end else begin
                    r = ((a % b) << W) | (a / b);  f = 1'b0; lat = W;
                end
            end
        endcase
        return {f, r[2*W-1:0]};
    endfunction

    task automatic loadAB(input int a, input int b);
        @(negedge clk);
        inA = W'(a); inB = W'(b); btnLoadA = 1'b1; btnLoadB = 1'b1;
        @(negedge clk);
        btnLoadA = 1'b0; btnLoadB = 1'b0;
    endtask

    // Pulses start for one edge; returns at the negedge right after the start edge
    task automatic startOp(input int a, input int b, input logic [1:0] o, input bit doPush, output int lat);
        logic [2*W:0] e;
        e = model(a, b, o, lat);
        @(negedge clk);
        op = o; start = 1'b1;
        if (doPush) expQ.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // n0 = edges already elapsed since the start edge (busy was high for each)
    task automatic waitDone(input string tag, input int lat, input int n0);
        int n;
        int busyCnt;
        logic [2*W:0] e;
        n = n0;
        busyCnt = n0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) busyCnt++;
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, lat);
        check({tag, " busy cycles"}, busyCnt, lat);
        check({tag, " busy with done"}, {31'd0, busy}, 32'd0);
        e = (expQ.size() > 0) ? expQ.pop_front() : {(2*W+1){1'bx}};
        check({tag, " result"}, {{(32-2*W){1'b0}}, result}, {{(32-2*W){1'b0}}, e[2*W-1:0]});
        check({tag, " flag"}, {31'd0, flag_out}, {31'd0, e[2*W]});
        @(negedge clk);
        check({tag, " done width"}, {31'd0, done}, 32'd0);
        check({tag, " result hold"}, {{(32-2*W){1'b0}}, result}, {{(32-2*W){1'b0}}, e[2*W-1:0]});
    endtask

    task automatic runOp(input string tag, input int a, input int b, input logic [1:0] o);
        int lat;
        loadAB(a, b);
        startOp(a, b, o, 1'b1, lat);
        waitDone(tag, lat, 0);
    endtask

    // Directed sequence
    initial begin
        int lat;
        int extra;
        rst = 1'b1; inA = '0; inB = '0; btnLoadA = 1'b0; btnLoadB = 1'b0;
        op = 2'b00; start = 1'b0;
        repeat (2) @(negedge clk);
        check("reset result", {24'd0, result}, 32'd0);
        check("reset flag",   {31'd0, flag_out}, 32'd0);
        check("reset busy",   {31'd0, busy}, 32'd0);
        check("reset done",   {31'd0, done}, 32'd0);
        rst = 1'b0;

        runOp("add 15+1", 15, 1, c_opAdd);
        runOp("add 7+8",  7,  8, c_opAdd);
        runOp("sub 1-3",  1,  3, c_opSub);
        runOp("sub 3-1",  3,  1, c_opSub);
        runOp("sub 5-5",  5,  5, c_opSub);
        runOp("mul 15*15", 15, 15, c_opMul);
        runOp("mul 2*3",  2,  3, c_opMul);
        runOp("mul 4*4",  4,  4, c_opMul);
        runOp("div 13/4", 13, 4, c_opDiv);
        runOp("div 9/0",  9,  0, c_opDiv);
        runOp("div 7/9",  7,  9, c_opDiv);

        // Second start plus a load of A while a DIV is running
        loadAB(13, 4);
        startOp(13, 4, c_opDiv, 1'b1, lat);
        inA = '0; btnLoadA = 1'b1; start = 1'b1;
        @(negedge clk);
        btnLoadA = 1'b0; start = 1'b0;
        waitDone("div midload", lat, 1);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        check("ignored start no done", extra, 0);
        startOp(0, 4, c_opAdd, 1'b1, lat);
        waitDone("regA cleared", lat, 0);

        // Reset during the second cycle of a MUL
        loadAB(15, 15);
        startOp(15, 15, c_opMul, 1'b0, lat);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst result", {24'd0, result}, 32'd0);
        check("midrst flag",   {31'd0, flag_out}, 32'd0);
        check("midrst busy",   {31'd0, busy}, 32'd0);
        check("midrst done",   {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        check("aborted op silent", extra, 0);
        runOp("add 2+3", 2, 3, c_opAdd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
